// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Two-requester round-robin front end for a single-port RW SRAM
//            macro. Clears the array after reset or on clr, then arbitrates
//            requesters A and B one access per cycle and routes read data
//            back to the requester that issued the read.
// Revision : 1.0  initial release
// ============================================================================
module sram_port_arbiter #(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 4,
   parameter int                    RAM_DEPTH  = 1 << ADDR_WIDTH,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk0,
   input  logic                  rst0_n,
   input  logic                  clr,
   input  logic                  a_req,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_gnt,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_req,
   input  logic                  b_we,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_gnt,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  init_done,
   output logic                  mem_csb0,
   output logic                  mem_web0,
   output logic [ADDR_WIDTH-1:0] mem_addr0,
   output logic [DATA_WIDTH-1:0] mem_din0,
   input  logic [DATA_WIDTH-1:0] mem_dout0
);

   localparam logic [0:0]            c_ST_INIT  = 1'b0;
   localparam logic [0:0]            c_ST_RUN   = 1'b1;
   localparam logic                  c_ID_A     = 1'b0;
   localparam logic                  c_ID_B     = 1'b1;
   localparam logic [ADDR_WIDTH-1:0] c_CNT_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  init_done_q, init_done_d;
   logic                  rr_q, rr_d;          // last granted requester
   logic                  csb_q, csb_d;
   logic                  web_q, web_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic                  trk0_rd_q, trk0_rd_d;  // read issued to macro this cycle
   logic                  trk0_id_q, trk0_id_d;
   logic                  trk1_rd_q, trk1_rd_d;  // read data returned this cycle
   logic                  trk1_id_q, trk1_id_d;
   logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
   logic                  grant_a, grant_b;

   // Round-robin selection; nothing is granted during INIT or while clr is high
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if ((state_q == c_ST_RUN) && !clr) begin
         if (a_req && (!b_req || (rr_q == c_ID_B))) begin
            grant_a = 1'b1;
         end else if (b_req) begin
            grant_b = 1'b1;
         end
      end
   end

   // Control FSM and macro command registers
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      rr_d        = rr_q;
      csb_d       = 1'b1;
      web_d       = web_q;
      addr_d      = addr_q;
      din_d       = din_q;
      case (state_q)
         c_ST_INIT: begin
            csb_d  = 1'b0;
            web_d  = 1'b0;
            addr_d = cnt_q;
            din_d  = INIT_VALUE;
            if (cnt_q == c_CNT_LAST) begin
               state_d     = c_ST_RUN;
               init_done_d = 1'b1;
               cnt_d       = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            if (clr) begin
               state_d     = c_ST_INIT;
               cnt_d       = '0;
               init_done_d = 1'b0;
            end else if (grant_a) begin
               csb_d  = 1'b0;
               web_d  = ~a_we;
               addr_d = a_addr;
               din_d  = a_wdata;
               rr_d   = c_ID_A;
            end else if (grant_b) begin
               csb_d  = 1'b0;
               web_d  = ~b_we;
               addr_d = b_addr;
               din_d  = b_wdata;
               rr_d   = c_ID_B;
            end
         end
      endcase
   end

   // Read tracking: stage 0 marks the cycle the macro performs the read,
   // stage 1 marks the cycle the captured data is presented to the requester
   always_comb begin
      trk0_rd_d = (grant_a & ~a_we) | (grant_b & ~b_we);
      trk0_id_d = grant_b ? c_ID_B : c_ID_A;
      trk1_rd_d = trk0_rd_q;
      trk1_id_d = trk0_id_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      if (trk0_rd_q) begin
         if (trk0_id_q == c_ID_A) begin
            a_rdata_d = mem_dout0;
         end else begin
            b_rdata_d = mem_dout0;
         end
      end
   end

   // State registers; reset drops in-flight reads and deselects the macro
   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         state_q     <= c_ST_INIT;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         rr_q        <= c_ID_B;
         csb_q       <= 1'b1;
         web_q       <= 1'b1;
         addr_q      <= '0;
         din_q       <= '0;
         trk0_rd_q   <= 1'b0;
         trk0_id_q   <= c_ID_A;
         trk1_rd_q   <= 1'b0;
         trk1_id_q   <= c_ID_A;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         rr_q        <= rr_d;
         csb_q       <= csb_d;
         web_q       <= web_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         trk0_rd_q   <= trk0_rd_d;
         trk0_id_q   <= trk0_id_d;
         trk1_rd_q   <= trk1_rd_d;
         trk1_id_q   <= trk1_id_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
      end
   end

   assign a_gnt     = grant_a;
   assign b_gnt     = grant_b;
   assign a_rvalid  = trk1_rd_q & (trk1_id_q == c_ID_A);
   assign b_rvalid  = trk1_rd_q & (trk1_id_q == c_ID_B);
   assign a_rdata   = a_rdata_q;
   assign b_rdata   = b_rdata_q;
   assign init_done = init_done_q;
   assign mem_csb0  = csb_q;
   assign mem_web0  = web_q;
   assign mem_addr0 = addr_q;
   assign mem_din0  = din_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_port_arbiter
// Brief    : Directed and random bench for sram_port_arbiter with a
//            behavioural SRAM macro and a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam logic [DW-1:0] INIT_V = 8'h00;

   logic          clk0 = 1'b0;
   logic          rst0_n = 1'b1;
   logic          clr = 1'b0;
   logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_wdata = '0, b_wdata = '0;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid, init_done;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          mem_csb0, mem_web0;
   logic [AW-1:0] mem_addr0;
   logic [DW-1:0] mem_din0;
   logic [DW-1:0] mem_dout0 = '0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   sram_port_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .INIT_VALUE(INIT_V)
   ) dut (
      .clk0(clk0), .rst0_n(rst0_n), .clr(clr),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .init_done(init_done),
      .mem_csb0(mem_csb0), .mem_web0(mem_web0), .mem_addr0(mem_addr0),
      .mem_din0(mem_din0), .mem_dout0(mem_dout0)
   );

   always #5 clk0 = ~clk0;

   always @(posedge clk0) cyc <= cyc + 1;

   // Behavioural macro: command registered at posedge, executed at the next negedge
   logic [DW-1:0] sram [DEPTH];
   logic          seeded = 1'b0;
   always @(negedge clk0) begin
      if (!seeded) begin
         for (int i = 0; i < DEPTH; i++) sram[i] <= DW'($urandom);
         seeded <= 1'b1;
      end else if (!mem_csb0) begin
         if (!mem_web0) sram[mem_addr0] <= mem_din0;
         else           mem_dout0 <= sram[mem_addr0];
      end
   end

   // ---------------- reference model ----------------
   typedef struct packed {
      int          due;
      logic        id;
      logic [DW-1:0] data;
   } rsp_t;

   typedef struct packed {
      logic          ga, gb, rva, rvb, done;
      logic [DW-1:0] rda, rdb;
   } obs_t;

   rsp_t          rq[$];
   logic [DW-1:0] m_mem [DEPTH];
   logic          m_init;
   int            m_idx;
   logic          m_last_b;
   logic          e_csb, e_web, e_done;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_din, e_rda, e_rdb;
   obs_t          ob;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      rq.delete();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT_V;
      m_init   = 1'b1;
      m_idx    = 0;
      m_last_b = 1'b1;
      e_csb = 1'b1; e_web = 1'b1; e_addr = '0; e_din = '0; e_done = 1'b0;
      e_rda = '0; e_rdb = '0;
   endtask

   // Called just after a posedge; reset is released before the next one
   task automatic do_reset();
      rst0_n = 1'b0;
      #1;
      check("rst_csb", 32'(mem_csb0), 32'd1);
      check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
      check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
      check("rst_init_done", 32'(init_done), 32'd0);
      model_reset();
      @(posedge clk0); #1;
      @(posedge clk0); #1;
      rst0_n = 1'b1;
   endtask

   // One clock cycle: drive, check at negedge against the model, advance model
   task automatic cycle(input logic ar, input logic aw, input logic [AW-1:0] aa,
                        input logic [DW-1:0] ad, input logic br, input logic bw,
                        input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                        input logic cl);
      logic eg_a, eg_b, erv_a, erv_b;
      a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
      b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
      clr = cl;
      @(negedge clk0);
      erv_a = 1'b0;
      erv_b = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         if (rq[0].id) begin erv_b = 1'b1; e_rdb = rq[0].data; end
         else          begin erv_a = 1'b1; e_rda = rq[0].data; end
         void'(rq.pop_front());
      end
      check("csb0", 32'(mem_csb0), 32'(e_csb));
      check("web0", 32'(mem_web0), 32'(e_web));
      check("addr0", 32'(mem_addr0), 32'(e_addr));
      check("din0", 32'(mem_din0), 32'(e_din));
      check("init_done", 32'(init_done), 32'(e_done));
      check("a_rvalid", 32'(a_rvalid), 32'(erv_a));
      check("b_rvalid", 32'(b_rvalid), 32'(erv_b));
      check("a_rdata", 32'(a_rdata), 32'(e_rda));
      check("b_rdata", 32'(b_rdata), 32'(e_rdb));
      eg_a = 1'b0;
      eg_b = 1'b0;
      if (!m_init && !cl) begin
         if (ar && br) begin
            if (m_last_b) eg_a = 1'b1; else eg_b = 1'b1;
         end else if (ar) eg_a = 1'b1;
         else if (br) eg_b = 1'b1;
      end
      check("a_gnt", 32'(a_gnt), 32'(eg_a));
      check("b_gnt", 32'(b_gnt), 32'(eg_b));
      ob = '{ga: a_gnt, gb: b_gnt, rva: a_rvalid, rvb: b_rvalid, done: init_done,
             rda: a_rdata, rdb: b_rdata};
      // accesses take effect in grant order; reads see all earlier writes
      if (eg_a) begin
         if (aw) m_mem[aa] = ad;
         else    rq.push_back('{due: cyc + 2, id: 1'b0, data: m_mem[aa]});
         m_last_b = 1'b0;
      end
      if (eg_b) begin
         if (bw) m_mem[ba] = bd;
         else    rq.push_back('{due: cyc + 2, id: 1'b1, data: m_mem[ba]});
         m_last_b = 1'b1;
      end
      if (m_init) begin
         e_csb = 1'b0; e_web = 1'b0; e_addr = AW'(m_idx); e_din = INIT_V;
         m_idx++;
         if (m_idx == DEPTH) begin m_init = 1'b0; e_done = 1'b1; end
      end else if (cl) begin
         e_csb = 1'b1; m_init = 1'b1; m_idx = 0; e_done = 1'b0;
         for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT_V;
      end else if (eg_a) begin
         e_csb = 1'b0; e_web = ~aw; e_addr = aa; e_din = ad;
      end else if (eg_b) begin
         e_csb = 1'b0; e_web = ~bw; e_addr = ba; e_din = bd;
      end else begin
         e_csb = 1'b1;
      end
      @(posedge clk0); #1;
   endtask

   task automatic idle();
      cycle(0, 0, '0, '0, 0, 0, '0, '0, 0);
   endtask

   initial begin
      int   rise;
      int   gcount, rvcount;
      logic ga_s [4];
      logic rva_s [6];
      logic rvb_s [6];
      logic [DW-1:0] rda_s [6];
      logic [DW-1:0] rdb_s [6];

      // ---- reset release, INIT writes 0..15, then read everything back ----
      #1;
      do_reset();
      rise = -1;
      for (int i = 0; i < 18; i++) begin
         idle();
         if (ob.done && rise < 0) rise = i;
      end
      check("init_done_rise_cycle", 32'(rise), 32'd16);
      for (int i = 0; i < DEPTH; i++) cycle(1, 0, AW'(i), '0, 0, 0, '0, '0, 0);
      idle(); idle();

      // ---- A writes 3=A5 then reads it back next cycle ----
      cycle(1, 1, 4'd3, 8'hA5, 0, 0, '0, '0, 0);
      check("raw_wr_gnt", 32'(ob.ga), 32'd1);
      cycle(1, 0, 4'd3, '0, 0, 0, '0, '0, 0);
      check("raw_rd_gnt", 32'(ob.ga), 32'd1);
      idle();
      check("raw_no_early_rvalid", 32'(ob.rva), 32'd0);
      idle();
      check("raw_rvalid", 32'(ob.rva), 32'd1);
      check("raw_rdata", 32'(ob.rda), 32'hA5);
      check("raw_b_quiet", 32'(ob.rvb), 32'd0);

      // ---- contention: alternating grants and responses ----
      cycle(1, 1, 4'd1, 8'h11, 0, 0, '0, '0, 0);
      cycle(0, 0, '0, '0, 1, 1, 4'd2, 8'h22, 0);
      for (int i = 0; i < 6; i++) begin
         if (i < 4) cycle(1, 0, 4'd1, '0, 1, 0, 4'd2, '0, 0);
         else       idle();
         if (i < 4) ga_s[i] = ob.ga;
         rva_s[i] = ob.rva; rvb_s[i] = ob.rvb;
         rda_s[i] = ob.rda; rdb_s[i] = ob.rdb;
      end
      for (int i = 0; i < 4; i++) check("rr_grant_a", 32'(ga_s[i]), 32'((i % 2) == 0));
      for (int i = 2; i < 6; i++) begin
         check("rr_rvalid_a", 32'(rva_s[i]), 32'((i % 2) == 0));
         check("rr_rvalid_b", 32'(rvb_s[i]), 32'((i % 2) == 1));
         if ((i % 2) == 0) check("rr_rdata_a", 32'(rda_s[i]), 32'h11);
         else              check("rr_rdata_b", 32'(rdb_s[i]), 32'h22);
      end

      // ---- B reads 5, clr next cycle with A requesting, re-init, read 5 ----
      cycle(0, 0, '0, '0, 1, 1, 4'd5, 8'h5C, 0);
      cycle(0, 0, '0, '0, 1, 0, 4'd5, '0, 0);
      cycle(1, 0, 4'd5, '0, 0, 0, '0, '0, 1);
      check("clr_no_gnt", 32'(ob.ga), 32'd0);
      gcount = 0;
      for (int i = 0; i < 16; i++) begin
         cycle(1, 0, 4'd5, '0, 0, 0, '0, '0, 0);
         if (i == 0) begin
            check("clr_inflight_rvalid", 32'(ob.rvb), 32'd1);
            check("clr_inflight_rdata", 32'(ob.rdb), 32'h5C);
         end
         check("clr_init_done_low", 32'(ob.done), 32'd0);
         gcount += int'(ob.ga);
      end
      check("clr_init_gnts", 32'(gcount), 32'd0);
      cycle(1, 0, 4'd5, '0, 0, 0, '0, '0, 0);
      check("post_clr_gnt", 32'(ob.ga), 32'd1);
      idle(); idle();
      check("post_clr_rdata", 32'(ob.rda), 32'h00);

      // ---- reset one cycle after an A read grant ----
      cycle(1, 1, 4'd7, 8'h3C, 0, 0, '0, '0, 0);
      cycle(1, 0, 4'd7, '0, 0, 0, '0, '0, 0);
      check("rst_rd_gnt", 32'(ob.ga), 32'd1);
      do_reset();
      gcount = 0;
      rvcount = 0;
      for (int i = 0; i < 16; i++) begin
         cycle(1, 0, 4'd7, '0, 0, 0, '0, '0, 0);
         gcount  += int'(ob.ga);
         rvcount += int'(ob.rva);
      end
      check("rst_init_gnts", 32'(gcount), 32'd0);
      check("rst_dropped_rvalid", 32'(rvcount), 32'd0);
      cycle(1, 0, 4'd7, '0, 0, 0, '0, '0, 0);
      check("post_rst_gnt", 32'(ob.ga), 32'd1);
      idle(); idle();
      check("post_rst_rdata", 32'(ob.rda), 32'h00);

      // ---- randomized traffic with occasional clr ----
      for (int i = 0; i < 400; i++) begin
         cycle(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
               1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom),
               ($urandom_range(0, 49) == 0));
      end
      for (int i = 0; i < 4; i++) idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Two-requester controller for the 16x8 single-port RW OpenRAM macro.
- Clears the array after reset or on request.
- Arbitrates requesters A and B round-robin, one access per cycle.
- Drives the macro's csb0/web0/addr0/din0 from registers and returns read data to the requester that issued the read.
- Sits between client logic and the macro instance; it is the only driver of the macro pins.

Parameters:
- DATA_WIDTH, 8, macro word width.
- ADDR_WIDTH, 4, macro address width.
- RAM_DEPTH, 1<<ADDR_WIDTH, words cleared by the init sequence.
- INIT_VALUE, 0, word written to every address during init.

Ports:
- clk0  in  1  clock; same clock as the macro clk0.
- rst0_n  in  1  asynchronous active-low reset.
- clr  in  1  single-cycle pulse; re-runs the init sequence.
- a_req  in  1  requester A access request.
- a_we  in  1  A: 1=write, 0=read.
- a_addr  in  ADDR_WIDTH  A address.
- a_wdata  in  DATA_WIDTH  A write data.
- a_gnt  out  1  A request accepted this cycle (combinational).
- a_rvalid  out  1  A read data valid (1 cycle).
- a_rdata  out  DATA_WIDTH  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A, for requester B.
- init_done  out  1  high once the array is cleared and arbitration is live.
- mem_csb0  out  1  to macro csb0 (active low).
- mem_web0  out  1  to macro web0 (active low write).
- mem_addr0  out  ADDR_WIDTH  to macro addr0.
- mem_din0  out  DATA_WIDTH  to macro din0.
- mem_dout0  in  DATA_WIDTH  from macro dout0.

Behaviour:
- Clocking and reset:
  - Single clock clk0.
  - rst0_n asynchronous, active-low.
  - All state updates on posedge clk0.
- Reset values:
  - mem_csb0=1, mem_web0=1, mem_addr0=0, mem_din0=0.
  - a/b_rvalid=0, a/b_rdata=0, init_done=0.
  - State=INIT with init counter=0.
  - RR pointer=B, so A wins the first tie.
  - Read-tracking pipeline cleared.
- Reset mid-operation:
  - In-flight reads are dropped; no rvalid is produced for them.
  - mem_csb0 goes to 1 immediately.
- FSM states: INIT and RUN.
- INIT:
  - Each cycle registers csb0=0, web0=0, addr0=cnt, din0=INIT_VALUE; cnt increments.
  - After the RAM_DEPTH-1 write is registered, next state is RUN and init_done=1.
  - INIT therefore lasts exactly RAM_DEPTH cycles.
  - Gnts are held 0 throughout INIT.
- RUN arbitration:
  - If exactly one req is high, that requester is granted.
  - If both are high, grant the requester other than the RR pointer.
  - The RR pointer updates to the granted requester.
  - x_gnt = (state==RUN) & selected; combinational, at most one high per cycle.
- Accepting a request:
  - On the posedge where gnt=1, register csb0=0, web0=~we, addr0=addr, din0=wdata.
  - With no grant, register csb0=1; web0/addr0/din0 hold.
- Requester handshake:
  - Requester holds req and its fields stable until it sees gnt.
  - The posedge with gnt consumes the request.
  - req held high afterwards is treated as a new request.
- Read latency, with gnt in cycle k:
  - Macro samples the command at posedge k+1.
  - Macro read data settles after negedge k+1.
  - Block captures mem_dout0 at posedge k+2 into x_rdata and asserts x_rvalid for the cycle following posedge k+2.
  - Read latency is fixed at 2 cycles from gnt, with one read in flight per cycle.
  - Tracking is a 2-stage shift register of {is_read, requester_id}.
- Write response: writes produce no response.
- Read-after-write to the same address in consecutive gnt cycles returns the new data: the macro writes at negedge before the following read is sampled.
- x_rdata holds its last value while x_rvalid=0.
- clr:
  - In RUN, clr enters INIT next cycle with cnt=0 and init_done=0.
  - No gnt is issued in the cycle clr is high.
  - Reads already in flight still complete and return their pre-clear data.
  - clr is ignored while in INIT.
- Addresses wrap only through width truncation; out-of-range addresses are impossible.

Test Plan:
- Reset release, no requests:
  - mem_csb0=0, web0=0 for 16 consecutive cycles, addr0 0..15, din0=0x00.
  - init_done rises after the 16th write; reads of 0..15 then return 0x00.
- A writes addr 3 = 0xA5, then A reads addr 3 next cycle:
  - a_gnt in both cycles.
  - a_rvalid exactly 2 cycles after the read gnt with a_rdata=0xA5; b_rvalid stays 0.
- A and B both hold read requests for 4 cycles (A addr 1, B addr 2, preloaded 0x11/0x22):
  - Grants alternate A,B,A,B.
  - rvalid pulses alternate with rdata 0x11, 0x22, 0x11, 0x22.
- B reads addr 5 (preloaded 0x5C), then clr pulses the next cycle:
  - b_rvalid returns 0x5C.
  - init_done drops and 16 clear writes follow.
  - A later read of addr 5 returns 0x00.
- rst0_n asserted one cycle after an A read gnt:
  - mem_csb0=1 immediately and no a_rvalid.
  - After release the full 16-cycle INIT repeats before any gnt.
